rc4_ksa_engine: RTL and testbench

RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

---
 rtl/rc4_ksa_engine_pkg.sv | 26 ++
 rtl/rc4_ksa_engine_key_sel.sv | 38 +++
 rtl/rc4_ksa_engine.sv | 168 ++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_ksa_engine_pkg.sv
// rc4_ksa_engine_pkg
// Shared constants for the RC4 key-scheduling engine: FSM state encoding,
// operation mode encodings and the S-box depth.
package rc4_ksa_engine_pkg;

  localparam int S_DEPTH = 256;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_INIT_WR = 4'd1;
  localparam state_t ST_RD_I    = 4'd2;
  localparam state_t ST_WAIT_I  = 4'd3;
  localparam state_t ST_CALC_J  = 4'd4;
  localparam state_t ST_RD_J    = 4'd5;
  localparam state_t ST_WAIT_J  = 4'd6;
  localparam state_t ST_WR_I    = 4'd7;
  localparam state_t ST_WR_J    = 4'd8;
  localparam state_t ST_DONE    = 4'd9;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_INIT = 2'b00;  // identity fill only
  localparam mode_t MODE_KSA  = 2'b01;  // key shuffle only
  localparam mode_t MODE_BOTH = 2'b10;  // fill then shuffle
  localparam mode_t MODE_RSVD = 2'b11;  // ignored

endpackage

// File: rtl/rc4_ksa_engine_key_sel.sv
// rc4_key_sel
// Holds the key-byte index and selects the current key byte.
// The index wraps at KEY_BYTES-1 with a compare, so no divider is needed.
// Ports:
//   clk, reset : clock, async active-high reset
//   clr        : force index to 0 (held while the engine is not shuffling)
//   adv        : step index by one, wrapping after the last key byte
//   key        : latched key, byte k at key[8k+7:8k]
//   key_byte   : key byte at the current index
module rc4_key_sel
  import rc4_ksa_engine_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   adv,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             key_byte
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] LAST = KW'(KEY_BYTES - 1);

  logic [KW-1:0]               kidx;
  logic [KEY_BYTES-1:0][7:0]   kb;

  assign kb       = key;
  assign key_byte = kb[kidx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        kidx <= '0;
    else if (clr)     kidx <= '0;
    else if (adv)     kidx <= (kidx == LAST) ? '0 : kidx + 1'b1;
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine
// RC4 key-scheduling engine driving an external 256x8 S memory.
// Mode 00 fills S[i]=i, mode 01 runs the key shuffle on the current S
// contents, mode 10 does both. Memory outputs are registered and asserted
// in the same cycle the FSM sits in the corresponding state.
// Ports:
//   clk, reset  : clock, async active-high reset
//   start, mode : operation request (sampled in IDLE) and its mode
//   secret_key  : key, latched on accepted start
//   mem_rdata   : S read data, valid RD_LAT cycles after mem_addr
//   mem_addr, mem_wdata, mem_wren : S memory address / write port
//   busy, done  : operation in progress / one-cycle completion pulse
module rc4_ksa_engine
  import rc4_ksa_engine_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wren,
  output logic                   busy,
  output logic                   done
);

  localparam logic [7:0] LAST_I = 8'(S_DEPTH - 1);
  localparam logic [1:0] WI_LAST = 2'(RD_LAT - 2);
  localparam logic [1:0] WJ_LAST = 2'(RD_LAT - 1);

  state_t                 state;
  mode_t                  mode_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i, j, si, sj;
  logic [1:0]             wcnt;
  logic [7:0]             key_byte;
  logic [7:0]             j_nxt, sj_nxt;
  logic                   sj_cap;

  // Index is held at 0 outside the shuffle, which also resets it at entry.
  rc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == ST_IDLE || state == ST_INIT_WR),
    .adv      (state == ST_CALC_J),
    .key      (key_q),
    .key_byte (key_byte)
  );

  assign j_nxt = j + mem_rdata + key_byte;

  // WAIT_J spends RD_LAT-1 cycles waiting plus one capture cycle in which
  // mem_rdata holds S[j]; the capture feeds the registered write data of
  // WR_I directly so the write lands in the very next cycle.
  assign sj_cap = (state == ST_WAIT_J) && (wcnt == WJ_LAST);
  assign sj_nxt = sj_cap ? mem_rdata : sj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_INIT;
      key_q     <= '0;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      wcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      sj       <= sj_nxt;
      case (state)
        ST_IDLE: begin
          if (start && mode != MODE_RSVD) begin
            mode_q   <= mode;
            key_q    <= secret_key;
            i        <= '0;
            j        <= '0;
            busy     <= 1'b1;
            mem_addr <= '0;
            if (mode == MODE_KSA) begin
              state <= ST_RD_I;
            end else begin
              state     <= ST_INIT_WR;
              mem_wdata <= '0;
              mem_wren  <= 1'b1;
            end
          end
        end
        ST_INIT_WR: begin
          i <= i + 8'd1;
          if (i == LAST_I) begin
            if (mode_q == MODE_BOTH) begin
              state    <= ST_RD_I;
              j        <= '0;
              mem_addr <= '0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            mem_addr  <= i + 8'd1;
            mem_wdata <= i + 8'd1;
            mem_wren  <= 1'b1;
          end
        end
        ST_RD_I: begin
          wcnt  <= '0;
          state <= (RD_LAT > 1) ? ST_WAIT_I : ST_CALC_J;
        end
        ST_WAIT_I: begin
          if (wcnt == WI_LAST) state <= ST_CALC_J;
          else                 wcnt  <= wcnt + 2'd1;
        end
        ST_CALC_J: begin
          si       <= mem_rdata;
          j        <= j_nxt;
          mem_addr <= j_nxt;
          wcnt     <= '0;
          state    <= ST_RD_J;
        end
        ST_RD_J: state <= ST_WAIT_J;
        ST_WAIT_J: begin
          if (sj_cap) begin
            mem_addr  <= i;
            mem_wdata <= sj_nxt;
            mem_wren  <= 1'b1;
            state     <= ST_WR_I;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        ST_WR_I: begin
          // With i==j this rewrites the same address; WR_J then leaves si there.
          mem_addr  <= j;
          mem_wdata <= si;
          mem_wren  <= 1'b1;
          state     <= ST_WR_J;
        end
        ST_WR_J: begin
          i <= i + 8'd1;
          if (i == LAST_I) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= ST_RD_I;
            mem_addr <= i + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: two instances (RD_LAT=1 and RD_LAT=2) share
// stimulus; each has its own S memory model. A reference KSA model pushes
// every expected memory write into per-instance queues; a monitor pops and
// compares on each write. Latency, done pulses and final S are also checked.
module tb_rc4_ksa_engine;

  localparam int KB = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    mode;
  logic [8*KB-1:0] key;
  logic [7:0]    rdata [2];
  logic [7:0]    addr  [2];
  logic [7:0]    wdata [2];
  logic          wren  [2];
  logic          busy  [2];
  logic          done  [2];

  always #5 clk = ~clk;

  rc4_ksa_engine #(.KEY_BYTES(KB), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .secret_key(key),
    .mem_rdata(rdata[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_wren(wren[0]), .busy(busy[0]), .done(done[0]));

  rc4_ksa_engine #(.KEY_BYTES(KB), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .secret_key(key),
    .mem_rdata(rdata[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_wren(wren[1]), .busy(busy[1]), .done(done[1]));

  // S memories: synchronous read, RD_LAT stages of read pipeline.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] p0a, p1a, p1b;
  always @(posedge clk) begin
    if (wren[0]) mem0[addr[0]] <= wdata[0];
    p0a <= mem0[addr[0]];
    if (wren[1]) mem1[addr[1]] <= wdata[1];
    p1a <= mem1[addr[1]];
    p1b <= p1a;
  end
  assign rdata[0] = p0a;
  assign rdata[1] = p1b;

  int n_chk = 0, n_pass = 0;
  int done_cnt [2] = '{0, 0};
  logic [15:0] q0[$], q1[$];
  logic [7:0]  ref_s [256];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, d, act, exp);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] dv);
    q0.push_back({a, dv});
    q1.push_back({a, dv});
  endtask

  // Reference model: textbook RC4 KSA on an array, emitting the write stream.
  task automatic model(input logic [1:0] m, input logic [23:0] k);
    int jj;
    logic [7:0] t, kbv;
    if (m == 2'b11) return;
    if (m != 2'b01)
      for (int x = 0; x < 256; x++) begin
        ref_s[x] = x[7:0];
        push(x[7:0], x[7:0]);
      end
    if (m != 2'b00) begin
      jj = 0;
      for (int x = 0; x < 256; x++) begin
        kbv = k[8*(x % KB) +: 8];
        jj = (jj + ref_s[x] + kbv) % 256;
        push(x[7:0], ref_s[jj]);
        push(jj[7:0], ref_s[x]);
        t = ref_s[x]; ref_s[x] = ref_s[jj]; ref_s[jj] = t;
      end
    end
  endtask

  task automatic mon_w(input int d);
    logic [15:0] e;
    int sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_chk++;
      $display("FAIL unexpected_write[dut%0d]: addr %0h data %0h, no write expected", d, addr[d], wdata[d]);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk("write", d, {16'h0, addr[d], wdata[d]}, {16'h0, e});
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) done_cnt[d]++;
      if (wren[d]) mon_w(d);
    end
  end

  task automatic run_op(input logic [1:0] m, input logic [23:0] k, input int restart_at, input int abort_at);
    int cyc, nbad, sz, exp_lat;
    int lat [2];
    bit fin [2];
    int dc0 [2];
    bit seen;
    dc0[0] = done_cnt[0]; dc0[1] = done_cnt[1];
    fin[0] = 1'b0; fin[1] = 1'b0;
    lat[0] = 0; lat[1] = 0;
    model(m, k);
    @(negedge clk);
    start = 1'b1; mode = m; key = k;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (m == 2'b11) begin
      seen = 1'b0;
      repeat (20) begin
        @(posedge clk); #1;
        if (busy[0] || busy[1]) seen = 1'b1;
      end
      chk("rsvd_busy", 0, {31'h0, seen}, 0);
      for (int d = 0; d < 2; d++) chk("rsvd_done", d, done_cnt[d] - dc0[d], 0);
      return;
    end
    for (int d = 0; d < 2; d++) chk("busy_after_start", d, {31'h0, busy[d]}, 1);
    while (!(fin[0] && fin[1]) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == restart_at) begin start = 1'b1; mode = 2'b01; key = ~k; end
      else start = 1'b0;
      if (cyc == abort_at) begin
        reset = 1'b1;
        q0.delete(); q1.delete();
        #1;
        for (int d = 0; d < 2; d++) begin
          chk("abort_wren", d, {31'h0, wren[d]}, 0);
          chk("abort_busy", d, {31'h0, busy[d]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      for (int d = 0; d < 2; d++)
        if (!fin[d] && done[d]) begin
          fin[d] = 1'b1;
          lat[d] = cyc;
          chk("busy_low_with_done", d, {31'h0, busy[d]}, 0);
        end
    end
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_lat = ((m != 2'b01) ? 256 : 0) + ((m != 2'b00) ? 256 * (4 + 2 * (d + 1)) : 0) + 1;
      if (!fin[d]) chk("done_timeout", d, 0, 1);
      else chk("latency", d, lat[d], exp_lat);
      chk("done_pulses", d, done_cnt[d] - dc0[d], 1);
      sz = (d == 0) ? q0.size() : q1.size();
      chk("writes_pending", d, sz, 0);
      nbad = 0;
      for (int x = 0; x < 256; x++)
        if (((d == 0) ? mem0[x] : mem1[x]) !== ref_s[x]) nbad++;
      chk("final_s_mismatches", d, nbad, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; key = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr", d, {24'h0, addr[d]}, 0);
      chk("rst_wdata", d, {24'h0, wdata[d]}, 0);
      chk("rst_wren", d, {31'h0, wren[d]}, 0);
      chk("rst_busy", d, {31'h0, busy[d]}, 0);
      chk("rst_done", d, {31'h0, done[d]}, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 24'h000000, 0, 0);   // identity fill
    run_op(2'b01, 24'h79654B, 0, 0);   // shuffle on identity, first writes S[0]=4B, S[4B]=0
    run_op(2'b10, 24'h79654B, 0, 0);   // full init + shuffle
    run_op(2'b00, 24'h000000, 0, 0);
    run_op(2'b01, 24'h123400, 0, 0);   // key byte0=0 on identity: i==j at i=0
    run_op(2'b00, 24'h000000, 5, 0);   // start pulsed while busy
    run_op(2'b11, 24'hABCDEF, 0, 0);   // reserved mode
    run_op(2'b10, 24'($urandom()), 0, 400);  // reset mid-shuffle
    run_op(2'b10, 24'($urandom()), 0, 0);
    run_op(2'b10, 24'($urandom()), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
